bp_be_dcache_lru_ctrl: RTL and testbench

//   Owns the tree-PLRU state for every set of the 8-way dcache and serialises all access to it.

---
 rtl/bp_be_dcache_lru_ctrl.sv | 169 ++++++++++++++++
 tb/tb_bp_be_dcache_lru_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_dcache_lru_ctrl.sv
// Tree-PLRU state keeper for the BE dcache: one 7-bit tree per set, touch updates,
// victim queries with a one-cycle registered result, and a post-reset clearing sweep.
module bp_be_dcache_lru_ctrl #(
  parameter  int sets_p     = 64,
  parameter  int ways_p     = 8,
  localparam int lg_sets_lp = $clog2(sets_p),
  localparam int lg_ways_lp = $clog2(ways_p),
  localparam int lru_w_lp   = ways_p - 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,

  input  logic                  touch_v_i,
  input  logic [lg_sets_lp-1:0] touch_set_i,
  input  logic [lg_ways_lp-1:0] touch_way_i,
  output logic                  touch_ready_o,

  input  logic                  victim_v_i,
  input  logic [lg_sets_lp-1:0] victim_set_i,
  output logic                  victim_ready_o,

  output logic                  victim_v_o,
  output logic [lg_ways_lp-1:0] victim_way_o,
  output logic [lru_w_lp-1:0]   victim_lru_o,

  output logic                  init_done_o
);

  typedef enum logic {
    e_init,
    e_ready
  } state_e;

  state_e                  state_q, state_d;
  logic [lg_sets_lp-1:0]   init_cnt_q, init_cnt_d;

  logic                    ready;
  logic                    init_we;
  logic                    touch_fire;
  logic                    victim_fire;

  logic [lru_w_lp-1:0]     touch_mask;
  logic [lru_w_lp-1:0]     touch_data;
  logic [lru_w_lp-1:0]     touch_new;
  logic [2:0]              touch_node1;
  logic [2:0]              touch_node2;

  logic [lru_w_lp-1:0]     lru_vec [sets_p];

  logic [lru_w_lp-1:0]     query_bits;
  logic [lg_ways_lp-1:0]   walk_way;
  logic [2:0]              walk_node1;
  logic [2:0]              walk_node2;

  logic                    victim_v_q, victim_v_d;
  logic [lg_ways_lp-1:0]   victim_way_q, victim_way_d;
  logic [lru_w_lp-1:0]     victim_lru_q, victim_lru_d;

  assign ready          = (state_q == e_ready);
  assign init_we        = (state_q == e_init);
  assign touch_fire     = touch_v_i & ready;
  assign victim_fire    = victim_v_i & ready;
  assign touch_ready_o  = ready;
  assign victim_ready_o = ready;
  assign init_done_o    = ready;

  // INIT clears one set per cycle; the last write moves us to READY.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == e_init) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == lg_sets_lp'(sets_p - 1)) begin
        state_d = e_ready;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= e_init;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // A touch writes the three tree nodes on the path to the way, pointing away from it.
  always_comb begin
    touch_mask  = '0;
    touch_data  = '0;
    touch_node1 = 3'd1 + {2'b00, touch_way_i[2]};
    touch_node2 = 3'd3 + {1'b0, touch_way_i[2], touch_way_i[1]};
    touch_mask[0]           = 1'b1;
    touch_data[0]           = ~touch_way_i[2];
    touch_mask[touch_node1] = 1'b1;
    touch_data[touch_node1] = ~touch_way_i[1];
    touch_mask[touch_node2] = 1'b1;
    touch_data[touch_node2] = ~touch_way_i[0];
  end

  assign touch_new = (lru_vec[touch_set_i] & ~touch_mask) | (touch_data & touch_mask);

  for (genvar gi = 0; gi < sets_p; gi++) begin : g_set
    logic                lru_q;
    logic [lru_w_lp-1:0] lru_bits_q;
    logic                we;
    logic [lru_w_lp-1:0] wdata;

    assign we    = (init_we && (init_cnt_q == lg_sets_lp'(gi)))
                 || (touch_fire && (touch_set_i == lg_sets_lp'(gi)));
    assign wdata = init_we ? '0 : touch_new;

    // Contents are left alone by reset; the INIT sweep clears them.
    always_ff @(posedge clk_i) begin
      if (we) begin
        lru_bits_q <= wdata;
      end
    end

    assign lru_q       = 1'b0;
    assign lru_vec[gi] = lru_bits_q | {lru_w_lp{lru_q}};
  end

  // Write-first: a same-cycle touch to the queried set is visible to the query.
  always_comb begin
    query_bits = lru_vec[victim_set_i];
    if (touch_fire && (touch_set_i == victim_set_i)) begin
      query_bits = touch_new;
    end
  end

  always_comb begin
    walk_way    = '0;
    walk_way[2] = query_bits[0];
    walk_node1  = 3'd1 + {2'b00, walk_way[2]};
    walk_way[1] = query_bits[walk_node1];
    walk_node2  = 3'd3 + {1'b0, walk_way[2], walk_way[1]};
    walk_way[0] = query_bits[walk_node2];
  end

  always_comb begin
    victim_v_d   = victim_fire;
    victim_way_d = victim_way_q;
    victim_lru_d = victim_lru_q;
    if (victim_fire) begin
      victim_way_d = walk_way;
      victim_lru_d = query_bits;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      victim_v_q   <= 1'b0;
      victim_way_q <= '0;
      victim_lru_q <= '0;
    end else begin
      victim_v_q   <= victim_v_d;
      victim_way_q <= victim_way_d;
      victim_lru_q <= victim_lru_d;
    end
  end

  assign victim_v_o   = victim_v_q;
  assign victim_way_o = victim_way_q;
  assign victim_lru_o = victim_lru_q;

endmodule

// File: tb/tb_bp_be_dcache_lru_ctrl.sv
// Randomized self-checking bench for bp_be_dcache_lru_ctrl against a heap-indexed PLRU tree model.
module tb_bp_be_dcache_lru_ctrl;

  localparam int SETS = 64;

  logic       clk;
  logic       reset_i;
  logic       touch_v_i;
  logic [5:0] touch_set_i;
  logic [2:0] touch_way_i;
  logic       touch_ready_o;
  logic       victim_v_i;
  logic [5:0] victim_set_i;
  logic       victim_ready_o;
  logic       victim_v_o;
  logic [2:0] victim_way_o;
  logic [6:0] victim_lru_o;
  logic       init_done_o;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  bit [6:0] tree_m [SETS];
  int       last_way;
  int       last_lru;

  bp_be_dcache_lru_ctrl #(.sets_p(SETS), .ways_p(8)) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .touch_v_i     (touch_v_i),
    .touch_set_i   (touch_set_i),
    .touch_way_i   (touch_way_i),
    .touch_ready_o (touch_ready_o),
    .victim_v_i    (victim_v_i),
    .victim_set_i  (victim_set_i),
    .victim_ready_o(victim_ready_o),
    .victim_v_o    (victim_v_o),
    .victim_way_o  (victim_way_o),
    .victim_lru_o  (victim_lru_o),
    .init_done_o   (init_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Heap-numbered tree: node n has children 2n+1 (lower half) and 2n+2 (upper half).
  function automatic bit [6:0] model_touch(input bit [6:0] t, input int w);
    int node = 0;
    for (int l = 0; l < 3; l++) begin
      int b = (w >> (2 - l)) & 1;
      t[node] = (b == 0);
      node = 2 * node + 1 + b;
    end
    return t;
  endfunction

  function automatic int model_victim(input bit [6:0] t);
    int node = 0;
    int v = 0;
    for (int l = 0; l < 3; l++) begin
      int b = int'(t[node]);
      v = v * 2 + b;
      node = 2 * node + 1 + b;
    end
    return v;
  endfunction

  // One clock cycle: drive at negedge, DUT samples at posedge, outputs checked at next negedge.
  task automatic step(input bit tv, input int ts, input int tw, input bit qv, input int qs);
    bit rdy;
    bit exp_v;
    rdy = (cyc >= SETS);
    touch_v_i    = tv;
    touch_set_i  = ts[5:0];
    touch_way_i  = tw[2:0];
    victim_v_i   = qv;
    victim_set_i = qs[5:0];
    #1;
    check("touch_ready", touch_ready_o, rdy);
    check("victim_ready", victim_ready_o, rdy);
    check("init_done", init_done_o, rdy);
    @(posedge clk);
    if (tv && rdy) tree_m[ts] = model_touch(tree_m[ts], tw);
    exp_v = qv && rdy;
    if (exp_v) begin
      last_way = model_victim(tree_m[qs]);
      last_lru = int'(tree_m[qs]);
    end
    cyc++;
    @(negedge clk);
    check("victim_v", victim_v_o, exp_v);
    check("victim_way", victim_way_o, last_way);
    check("victim_lru", victim_lru_o, last_lru);
    $display("cyc=%0d t=%0b/%0d/%0d q=%0b/%0d -> v=%0b way=%0d lru=%02h", cyc, tv, ts, tw, qv, qs,
             victim_v_o, victim_way_o, victim_lru_o);
  endtask

  // Called at a negedge; checks outputs clear asynchronously, then releases reset at a negedge.
  task automatic do_reset();
    reset_i = 1'b1;
    #1;
    check("rst_victim_v", victim_v_o, 0);
    check("rst_victim_way", victim_way_o, 0);
    check("rst_victim_lru", victim_lru_o, 0);
    check("rst_init_done", init_done_o, 0);
    check("rst_touch_ready", touch_ready_o, 0);
    check("rst_victim_ready", victim_ready_o, 0);
    last_way = 0;
    last_lru = 0;
    for (int s = 0; s < SETS; s++) tree_m[s] = '0;
    cyc = 0;
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b0;
  endtask

  task automatic run_init(input bit noisy);
    for (int i = 0; i < SETS; i++) begin
      if (noisy) step(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7),
                      1'($urandom_range(0, 1)), $urandom_range(0, 7));
      else step(0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    reset_i      = 1'b1;
    touch_v_i    = 1'b0;
    touch_set_i  = '0;
    touch_way_i  = '0;
    victim_v_i   = 1'b0;
    victim_set_i = '0;
    @(negedge clk);
    do_reset();

    // Requests during INIT must be ignored; ready/init_done checked every cycle.
    run_init(1'b1);

    step(0, 0, 0, 1, 5);
    check("t1_way", victim_way_o, 0);
    check("t1_lru", victim_lru_o, 7'h00);

    step(1, 3, 0, 0, 0);
    step(0, 0, 0, 1, 3);
    check("t2_lru", victim_lru_o, 7'h0B);
    check("t2_way", victim_way_o, 4);
    step(0, 0, 0, 1, 2);
    check("t2_other_way", victim_way_o, 0);

    step(1, 9, 0, 0, 0);
    step(1, 9, 4, 0, 0);
    step(1, 9, 2, 0, 0);
    step(1, 9, 6, 0, 0);
    step(0, 0, 0, 1, 9);
    check("t3_lru", victim_lru_o, 7'h78);
    check("t3_way", victim_way_o, 1);

    step(1, 11, 0, 1, 11);
    check("t4_bypass_v", victim_v_o, 1);
    check("t4_bypass_way", victim_way_o, 4);
    check("t4_bypass_lru", victim_lru_o, 7'h0B);
    step(1, 12, 5, 1, 13);
    check("t4_indep_way", victim_way_o, 0);

    for (int i = 0; i < 600; i++) begin
      int ts;
      int qs;
      ts = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7);
      qs = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7);
      if ($urandom_range(0, 4) == 0) qs = ts;
      step(1'($urandom_range(0, 1)), ts, $urandom_range(0, 7), 1'($urandom_range(0, 1)), qs);
    end

    // Reset mid-INIT, then again with a query result on the outputs.
    do_reset();
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0);
    do_reset();
    run_init(1'b0);
    step(1, 3, 0, 0, 0);
    step(0, 0, 0, 1, 3);
    check("t6_pre_lru", victim_lru_o, 7'h0B);
    do_reset();
    run_init(1'b1);
    step(0, 0, 0, 1, 3);
    check("t6_way", victim_way_o, 0);
    check("t6_lru", victim_lru_o, 7'h00);
    step(0, 0, 0, 0, 0);
    check("t6_idle_v", victim_v_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
